// File: rtl/fir_tap_sequencer_pkg.sv
// rtl/fir_tap_sequencer_pkg.sv - shared state encoding and default sizes for the FIR tap sequencer
package fir_tap_sequencer_pkg;

    localparam int NTAPS_DEF = 8;
    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 3;
    localparam int ACCW_DEF  = 39;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular sample buffer with write pointer and (base - tap) read port
module fir_delay_line #(
    parameter int NTAPS = 8,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          R,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] tap,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NTAPS];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (R) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            base   <= '0;
        end else if (we) begin
            mem[wr_ptr] <= wdata;
            base        <= wr_ptr;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    // AW-bit subtraction wraps modulo NTAPS, so tap 0 is the newest sample
    assign rd_addr = base - tap;
    assign rdata   = mem[rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - sample intake, coefficient bank and MAC operand sequencing FSM
module fir_tap_sequencer
    import fir_tap_sequencer_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int ACCW  = ACCW_DEF
) (
    input  logic            clk,
    input  logic            R,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_sample,
    output logic            in_ready,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [DW-1:0]   coef_data,
    output logic [DW-1:0]   mac_x,
    output logic [DW-1:0]   mac_b,
    output logic            mac_clr,
    input  logic [ACCW-1:0] acc_in,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);

    state_t        state, state_next;
    logic [AW-1:0] tap;
    logic [DW-1:0] coef [NTAPS];
    logic [DW-1:0] dline_rdata;
    logic          accept;
    logic          idle;

    assign idle   = (state == IDLE);
    assign accept = idle && in_valid;

    fir_delay_line #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .AW    (AW)
    ) u_dline (
        .clk   (clk),
        .R     (R),
        .we    (accept),
        .wdata (in_sample),
        .tap   (tap),
        .rdata (dline_rdata)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (R || state == CLEAR) begin
            tap <= '0;
        end else if (state == RUN) begin
            tap <= tap + 1'b1;
        end
    end

    // Writes land only in IDLE, so a same-cycle accept already sees the new value in RUN
    always_ff @(posedge clk) begin
        if (R) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (idle && coef_we) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state == DONE);
            if (state == DONE) begin
                out_data <= acc_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        mac_x      = '0;
        mac_b      = '0;
        mac_clr    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                mac_x = dline_rdata;
                mac_b = coef[tap];
                if (tap == AW'(NTAPS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - scoreboard bench for the FIR tap sequencer with a behavioural MAC ALU
module tb_fir_tap_sequencer;

    localparam int NTAPS = 8;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int ACCW  = 39;

    logic            clk = 1'b0;
    logic            R;
    logic            in_valid;
    logic [DW-1:0]   in_sample;
    logic            in_ready;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [DW-1:0]   coef_data;
    logic [DW-1:0]   mac_x;
    logic [DW-1:0]   mac_b;
    logic            mac_clr;
    logic [ACCW-1:0] acc_in;
    logic            out_valid;
    logic [ACCW-1:0] out_data;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [ACCW-1:0] sb [$];
    int mh [NTAPS];
    int mc [NTAPS];
    int mp;

    always #5 clk = ~clk;

    fir_tap_sequencer #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .AW    (AW),
        .ACCW  (ACCW)
    ) dut (
        .clk       (clk),
        .R         (R),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mac_x     (mac_x),
        .mac_b     (mac_b),
        .mac_clr   (mac_clr),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    // MAC ALU: signed 16x16 product sign-extended into a 39-bit accumulator, cleared by R | mac_clr
    logic signed [31:0] prod;
    assign prod = $signed(mac_x) * $signed(mac_b);
    always @(posedge clk) begin
        if (R || mac_clr) acc_in <= '0;
        else              acc_in <= acc_in + {{(ACCW-32){prod[31]}}, prod};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check("out_data", 64'(out_data), 64'(sb.pop_front()));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NTAPS; i++) begin
            mh[i] = 0;
            mc[i] = 0;
        end
        mp = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        R = 1'b1;
        @(posedge clk);
        #1;
        R = 1'b0;
        model_clear();
    endtask

    // Returns 1 time unit after the acceptance edge E0
    task automatic accept(input int s, input bit wr, input int a, input int d, input bit push);
        int  n;
        int  base;
        longint sum;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_sample = DW'(s);
        coef_we   = wr;
        coef_addr = AW'(a);
        coef_data = DW'(d);
        if (wr) mc[a] = d;
        mh[mp] = s;
        base   = mp;
        mp     = (mp + 1) % NTAPS;
        sum    = 0;
        for (int k = 0; k < NTAPS; k++) begin
            sum += longint'(mc[k]) * longint'(mh[(base - k + NTAPS) % NTAPS]);
        end
        if (push) sb.push_back(ACCW'(sum));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = DW'(d);
        mc[a]     = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && in_ready) break;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        R         = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        R = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_mac_x", 64'(mac_x), 64'd0);
        check("rst_mac_b", 64'(mac_b), 64'd0);
        check("rst_mac_clr", 64'(mac_clr), 64'd0);

        // same-cycle coefficient write and sample accept on an empty filter
        accept(2, 1'b1, 0, 5, 1'b1);
        wait_idle();

        // impulse response, with latency checks around the first sample
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
        accept(1, 1'b0, 0, 0, 1'b1);
        check("t0_mac_clr", 64'(mac_clr), 64'd1);
        check("t0_in_ready", 64'(in_ready), 64'd0);
        check("t0_busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("t1_mac_clr", 64'(mac_clr), 64'd0);
            if (k == 9) begin
                check("t9_in_ready", 64'(in_ready), 64'd0);
                check("t9_out_valid", 64'(out_valid), 64'd0);
            end
            if (k == 10) begin
                check("t10_out_valid", 64'(out_valid), 64'd1);
                check("t10_in_ready", 64'(in_ready), 64'd1);
            end
            if (k == 11) check("t11_out_valid", 64'(out_valid), 64'd0);
        end
        wait_idle();
        for (int i = 0; i < NTAPS; i++) begin
            accept(0, 1'b0, 0, 0, 1'b1);
            wait_idle();
        end

        // step response and wrap-around
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 2);
        for (int i = 0; i < NTAPS + 1; i++) begin
            accept(3, 1'b0, 0, 0, 1'b1);
            wait_idle();
        end

        // in_valid and coef_we during RUN must be ignored
        accept(3, 1'b0, 0, 0, 1'b1);
        in_valid  = 1'b1;
        in_sample = DW'(77);
        repeat (3) @(posedge clk);
        #1;
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = DW'(100);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("run_in_ready", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        accept(3, 1'b0, 0, 0, 1'b1);
        wait_idle();

        // reset while tap == 4 aborts the sequence
        accept(5, 1'b0, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        R = 1'b1;
        @(posedge clk);
        #1;
        R = 1'b0;
        model_clear();
        repeat (15) @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        accept(7, 1'b0, 0, 0, 1'b1);
        wait_idle();
        write_coef(1, 4);
        accept(6, 1'b0, 0, 0, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
